// File: rtl/hist_pkg.sv
// Shared definitions for the histogram sequencer: fixed bin geometry and
// the sequencer state encoding.
package hist_pkg;

  localparam int unsigned HIST_NUM_BINS  = 8;
  localparam int unsigned HIST_BIN_W     = 14;
  localparam int unsigned HIST_BIN_IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RDADDR = 3'd4,
    ST_RDWAIT = 3'd5,
    ST_OUT    = 3'd6,
    ST_FIN    = 3'd7
  } hist_state_e;

  // Frame in progress: CLEAR through OUT.
  function automatic logic hist_is_busy(input hist_state_e s);
    return (s != ST_IDLE) && (s != ST_FIN);
  endfunction

endpackage

// File: rtl/hist_pix_fetch.sv
// Pixel fetch engine for hist_ctrl.
// Generates the image-memory read strobe and address, and delays the strobe
// by one cycle so the histogram count enable lines up with returned pixel data.
// Ports:
//   clk, rst  clock / synchronous active-high reset
//   clr       zero the address counter
//   run       fetch one pixel this cycle
//   pix_rd    image memory read strobe
//   pix_addr  image memory address
//   hist_en   histogram count enable (pix_rd delayed one cycle)
//   last      current address is the final pixel of the frame
module hist_pix_fetch
  import hist_pkg::*;
#(
  parameter int unsigned NUM_PIX = 16383,
  parameter int unsigned PIX_AW  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              run,
  output logic              pix_rd,
  output logic [PIX_AW-1:0] pix_addr,
  output logic              hist_en,
  output logic              last
);

  localparam logic [PIX_AW-1:0] LAST_ADDR = PIX_AW'(NUM_PIX - 1);

  logic [PIX_AW-1:0] addr_q, addr_d;
  logic              hist_en_q, hist_en_d;

  assign last     = (addr_q == LAST_ADDR);
  assign pix_rd   = run;
  assign pix_addr = addr_q;
  assign hist_en  = hist_en_q;

  // Counter parks on the last address rather than wrapping, which also keeps
  // NUM_PIX == 2**PIX_AW safe.
  always_comb begin
    addr_d    = addr_q;
    hist_en_d = run;
    if (clr) begin
      addr_d = '0;
    end else if (run && !last) begin
      addr_d = addr_q + PIX_AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      hist_en_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      hist_en_q <= hist_en_d;
    end
  end

endmodule

// File: rtl/hist_ctrl.sv
// Histogram sequencer: on start, clears the 8-bin histogram, streams NUM_PIX
// pixels from image memory into it, then reads back every bin and presents
// it on a valid/ready stream.
// Ports:
//   clk, rst               clock / synchronous active-high reset
//   start                  1-cycle frame request (honoured only when idle)
//   busy, done             frame in progress / 1-cycle completion pulse
//   pix_rd, pix_addr       image memory read port
//   pix_data               pixel, valid one cycle after pix_rd
//   hist_clr, hist_en      histogram clear pulse / count enable
//   hist_din               pixel passed to histogram
//   hist_addr, hist_q      bin readback port (hist_q one cycle after addr)
//   bin_valid, bin_ready   output stream handshake
//   bin_idx, bin_data      presented bin index / count
// Optional build macro HIST_CTRL_SUMCHK_EN adds output sum_err: set at the end
// of a frame when the emitted bin counts do not total NUM_PIX.
module hist_ctrl
  import hist_pkg::*;
#(
  parameter int unsigned NUM_PIX  = 16383,
  parameter int unsigned PIX_AW   = 14,
  parameter int unsigned BIN_W    = HIST_BIN_W,
  parameter int unsigned NUM_BINS = HIST_NUM_BINS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      pix_rd,
  output logic [PIX_AW-1:0]         pix_addr,
  input  logic [7:0]                pix_data,
  output logic                      hist_clr,
  output logic                      hist_en,
  output logic [7:0]                hist_din,
  output logic [HIST_BIN_IDX_W-1:0] hist_addr,
  input  logic [BIN_W-1:0]          hist_q,
  output logic                      bin_valid,
  input  logic                      bin_ready,
  output logic [HIST_BIN_IDX_W-1:0] bin_idx,
  output logic [BIN_W-1:0]          bin_data
`ifdef HIST_CTRL_SUMCHK_EN
  ,
  output logic                      sum_err
`endif
);

  localparam logic [HIST_BIN_IDX_W-1:0] LAST_BIN = HIST_BIN_IDX_W'(NUM_BINS - 1);

  hist_state_e               state_q, state_d;
  logic [HIST_BIN_IDX_W-1:0] k_q, k_d;
  logic [BIN_W-1:0]          bin_data_q, bin_data_d;
  logic                      fetch_run;
  logic                      fetch_last;
  logic                      start_acc;
  logic                      handshake;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign handshake = (state_q == ST_OUT) && bin_ready;

  hist_pix_fetch #(
    .NUM_PIX (NUM_PIX),
    .PIX_AW  (PIX_AW)
  ) u_fetch (
    .clk      (clk),
    .rst      (rst),
    .clr      (hist_clr),
    .run      (fetch_run),
    .pix_rd   (pix_rd),
    .pix_addr (pix_addr),
    .hist_en  (hist_en),
    .last     (fetch_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_FETCH;
      ST_FETCH:  if (fetch_last) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_RDADDR;
      ST_RDADDR: state_d = ST_RDWAIT;
      ST_RDWAIT: state_d = ST_OUT;
      ST_OUT:    if (bin_ready) state_d = (k_q == LAST_BIN) ? ST_FIN : ST_RDADDR;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy      = hist_is_busy(state_q);
    done      = (state_q == ST_FIN);
    hist_clr  = (state_q == ST_CLEAR);
    fetch_run = (state_q == ST_FETCH);
    bin_valid = (state_q == ST_OUT);
  end

  assign hist_din  = pix_data;
  assign hist_addr = k_q;
  assign bin_idx   = k_q;
  assign bin_data  = bin_data_q;

  // Readout datapath: hist_q reflects hist_addr during RDWAIT, so capture at
  // the end of RDWAIT and hold through OUT until accepted.
  always_comb begin
    k_d        = k_q;
    bin_data_d = bin_data_q;
    if (hist_clr || done) begin
      k_d = '0;
    end else if (handshake && (k_q != LAST_BIN)) begin
      k_d = k_q + HIST_BIN_IDX_W'(1);
    end
    if (state_q == ST_RDWAIT) begin
      bin_data_d = hist_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      bin_data_q <= '0;
    end else begin
      k_q        <= k_d;
      bin_data_q <= bin_data_d;
    end
  end

`ifdef HIST_CTRL_SUMCHK_EN
  logic [BIN_W+2:0] sum_q, sum_d;
  logic             sum_err_q, sum_err_d;

  always_comb begin
    sum_d     = sum_q;
    sum_err_d = sum_err_q;
    if (start_acc) begin
      sum_d     = '0;
      sum_err_d = 1'b0;
    end else if (handshake) begin
      sum_d = sum_q + (BIN_W+3)'(bin_data_q);
    end
    if (done) begin
      sum_err_d = (sum_q != (BIN_W+3)'(NUM_PIX));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      sum_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      sum_err_q <= sum_err_d;
    end
  end

  assign sum_err = sum_err_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_hist_ctrl.sv
// Directed bench for hist_ctrl with a 256-pixel frame (PIX_AW=8, so the
// address counter runs to its full range). Behavioural image memory and
// histogram unit surround the DUT; expected bins are hand-computed constants.
`timescale 1ns/1ps
module tb_hist_ctrl;

  localparam int NPIX = 256;
  localparam int LAT  = 1 + NPIX + 1 + 24 + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done;
  logic        pix_rd;
  logic [7:0]  pix_addr;
  logic [7:0]  pix_data = 8'h00;
  logic        hist_clr, hist_en;
  logic [7:0]  hist_din;
  logic [2:0]  hist_addr;
  logic [13:0] hist_q = '0;
  logic        bin_valid, bin_ready;
  logic [2:0]  bin_idx;
  logic [13:0] bin_data;
`ifdef HIST_CTRL_SUMCHK_EN
  logic        sum_err;
`endif

  always #5 clk = ~clk;

  hist_ctrl #(
    .NUM_PIX  (NPIX),
    .PIX_AW   (8),
    .BIN_W    (14),
    .NUM_BINS (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pix_rd    (pix_rd),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .hist_clr  (hist_clr),
    .hist_en   (hist_en),
    .hist_din  (hist_din),
    .hist_addr (hist_addr),
    .hist_q    (hist_q),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready),
    .bin_idx   (bin_idx),
    .bin_data  (bin_data)
`ifdef HIST_CTRL_SUMCHK_EN
    ,
    .sum_err   (sum_err)
`endif
  );

  // Image memory and histogram unit models
  logic [7:0]  mem [NPIX];
  logic [13:0] hbin [8];
  bit          corrupt = 1'b0;
  int          en_cnt = 0, clr_cnt = 0;

  always @(posedge clk) begin
    pix_data <= pix_rd ? mem[pix_addr] : 8'h00;
    if (hist_clr) begin
      for (int b = 0; b < 8; b++) hbin[b] <= '0;
    end else if (hist_en) begin
      hbin[hist_din[7:5]] <= hbin[hist_din[7:5]] + 14'd1;
    end
    hist_q <= hbin[hist_addr] - ((corrupt && hist_addr == 3'd0) ? 14'd1 : 14'd0);
    if (hist_en)  en_cnt  <= en_cnt + 1;
    if (hist_clr) clr_cnt <= clr_cnt + 1;
  end

  // Output stream and done monitor
  int cap_idx [128];
  int cap_data[128];
  int n_cap = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (bin_valid && bin_ready && n_cap < 128) begin
      cap_idx[n_cap]  <= int'(bin_idx);
      cap_data[n_cap] <= int'(bin_data);
      n_cap           <= n_cap + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_vec = 0, n_miss = 0;
  int exp_bin[8];
  int cap_base, en_base, done_base, clr_base;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string pre);
    chk({pre, " busy"},      32'(busy),      0);
    chk({pre, " done"},      32'(done),      0);
    chk({pre, " pix_rd"},    32'(pix_rd),    0);
    chk({pre, " pix_addr"},  32'(pix_addr),  0);
    chk({pre, " hist_clr"},  32'(hist_clr),  0);
    chk({pre, " hist_en"},   32'(hist_en),   0);
    chk({pre, " hist_addr"}, 32'(hist_addr), 0);
    chk({pre, " bin_valid"}, 32'(bin_valid), 0);
    chk({pre, " bin_idx"},   32'(bin_idx),   0);
    chk({pre, " bin_data"},  32'(bin_data),  0);
`ifdef HIST_CTRL_SUMCHK_EN
    chk({pre, " sum_err"},   32'(sum_err),   0);
`endif
  endtask

  // mode 0: plain, 1: stall bin 3 for 5 cycles, 2: stray start in FETCH,
  // 3: reset when pix_addr reaches 100 (frame aborted)
  task automatic run_frame(input int mode, output int lat);
    int held;
    bit aborted;
    held    = 0;
    aborted = 1'b0;
    @(posedge clk); #1;
    cap_base  = n_cap;
    en_base   = en_cnt;
    done_base = done_cnt;
    clr_base  = clr_cnt;
    start     = 1'b1;
    bin_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    chk("clear pulse", 32'(hist_clr), 1);
    chk("busy in clear", 32'(busy), 1);
`ifdef HIST_CTRL_SUMCHK_EN
    chk("sum_err cleared by start", 32'(sum_err), 0);
`endif
    @(posedge clk); #1;
    lat = 2;
    chk("first fetch rd", 32'(pix_rd), 1);
    chk("first fetch addr", 32'(pix_addr), 0);
    while (!done && !aborted && lat < 2000) begin
      start = (mode == 2 && lat == 50);
      if (mode == 3 && pix_rd && pix_addr == 8'd100) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        aborted = 1'b1;
      end else begin
        if (mode == 1 && bin_valid && bin_idx == 3'd3 && held < 5) begin
          bin_ready = 1'b0;
          chk("stall valid", 32'(bin_valid), 1);
          chk("stall idx", 32'(bin_idx), 3);
          chk("stall data", 32'(bin_data), 32'(exp_bin[3]));
          held++;
        end else begin
          bin_ready = 1'b1;
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    start     = 1'b0;
    bin_ready = 1'b1;
    if (!aborted) begin
      if (!done) chk("done timeout", 0, 1);
      else       chk("busy low in fin", 32'(busy), 0);
    end
  endtask

  task automatic check_bins(input string name);
    chk({name, " handshakes"}, 32'(n_cap - cap_base), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s idx%0d", name, i), 32'(cap_idx[cap_base + i]), 32'(i));
      chk($sformatf("%s bin%0d", name, i), 32'(cap_data[cap_base + i]), 32'(exp_bin[i]));
    end
    chk({name, " hist_en pulses"}, 32'(en_cnt - en_base), NPIX);
    chk({name, " clr pulses"}, 32'(clr_cnt - clr_base), 1);
  endtask

  int lat;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    bin_ready = 1'b1;
    for (int b = 0; b < 8; b++) hbin[b] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_outputs("reset");

    // 1: uniform pixel 10 -> all counts land in bin 0
    for (int i = 0; i < NPIX; i++) mem[i] = 8'd10;
    exp_bin = '{256, 0, 0, 0, 0, 0, 0, 0};
    run_frame(0, lat);
    chk("t1 latency", 32'(lat), LAT);
    check_bins("t1");

    // 2: ramp 0..255, started right after the previous done -> 32 per bin
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
    exp_bin = '{32, 32, 32, 32, 32, 32, 32, 32};
    run_frame(0, lat);
    chk("t2 latency", 32'(lat), LAT);
    check_bins("t2");

    // 3: back-pressure on bin 3
    run_frame(1, lat);
    chk("t3 latency", 32'(lat), LAT + 5);
    check_bins("t3");

    // 4: stray start during FETCH is dropped
    run_frame(2, lat);
    chk("t4 latency", 32'(lat), LAT);
    check_bins("t4");
    repeat (300) @(posedge clk);
    #1;
    chk("t4 single done", 32'(done_cnt - done_base), 1);
    chk("t4 idle after", 32'(busy), 0);

    // 5: reset mid-FETCH, then a full frame from scratch
    for (int i = 0; i < NPIX; i++) mem[i] = 8'd10;
    run_frame(3, lat);
    check_idle_outputs("t5 after rst");
    repeat (3) @(posedge clk);
    #1;
    chk("t5 pixels counted", 32'(en_cnt - en_base), 100);
    chk("t5 no done", 32'(done_cnt - done_base), 0);
    chk("t5 no extra clr", 32'(clr_cnt - clr_base), 1);
    chk("t5 stays idle", 32'(busy), 0);
    exp_bin = '{256, 0, 0, 0, 0, 0, 0, 0};
    run_frame(0, lat);
    chk("t5 latency", 32'(lat), LAT);
    check_bins("t5");

`ifdef HIST_CTRL_SUMCHK_EN
    // 6: bin 0 reads back one short -> sum 255 flags error, held until start
    corrupt = 1'b1;
    exp_bin = '{255, 0, 0, 0, 0, 0, 0, 0};
    run_frame(0, lat);
    check_bins("t6 bad");
    @(posedge clk); #1;
    chk("t6 sum_err set", 32'(sum_err), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("t6 sum_err held", 32'(sum_err), 1);
    corrupt = 1'b0;
    exp_bin = '{256, 0, 0, 0, 0, 0, 0, 0};
    run_frame(0, lat);
    check_bins("t6 good");
    @(posedge clk); #1;
    chk("t6 sum_err clear", 32'(sum_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
